// File: rtl/reg_scoreboard_ctrl_pkg.sv
// reg_scoreboard_ctrl_pkg: shared widths, slot record and FSM state for the issue/hazard scoreboard
package reg_scoreboard_ctrl_pkg;
  localparam int REG_NO_WIDTH = 4;
  localparam int NUM_REGS = 2 ** REG_NO_WIDTH;
  localparam int DEF_PIPE_DEPTH = 3;
  localparam int DEF_FLUSH_DEPTH = 2;
  localparam int DEF_FLUSH_HOLD = 2;
  typedef struct packed {
    logic valid;
    logic [REG_NO_WIDTH-1:0] regNo;
  } slot_t;
  typedef enum logic {RUN, HOLD} state_t;
endpackage

// File: rtl/reg_scoreboard_ctrl_sb_slot_pipe.sv
// sb_slot_pipe: shifting in-flight write tracker with flush kill, RAW match and pending mask
module sb_slot_pipe import reg_scoreboard_ctrl_pkg::*; #(
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
  parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic [REG_NO_WIDTH-1:0] i_push_no,
  input  logic                    i_flush,
  input  logic                    i_src1_use,
  input  logic [REG_NO_WIDTH-1:0] i_src1_no,
  input  logic                    i_src2_use,
  input  logic [REG_NO_WIDTH-1:0] i_src2_no,
  output slot_t                   o_tail,
  output logic                    o_hazard,
  output logic [NUM_REGS-1:0]     o_pending_mask
);
  slot_t r_slot [PIPE_DEPTH];
  slot_t w_next [PIPE_DEPTH];
  logic [NUM_REGS-1:0] w_mask;
  always_comb begin
    w_next[0] = '{valid: i_push, regNo: i_push_no};
    for (int i = 1; i < PIPE_DEPTH; i++) w_next[i] = r_slot[i-1];
    // flush leaves the youngest positions empty after the shift
    for (int i = 0; i < FLUSH_DEPTH; i++) if (i_flush) w_next[i].valid = 1'b0;
    w_mask = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) if (w_next[i].valid) w_mask[w_next[i].regNo] = 1'b1;
    o_hazard = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++)
      if (r_slot[i].valid && ((i_src1_use && i_src1_no == r_slot[i].regNo) ||
                              (i_src2_use && i_src2_no == r_slot[i].regNo)))
        o_hazard = 1'b1;
  end
  assign o_tail = r_slot[PIPE_DEPTH-1];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) r_slot[i] <= '0;
      o_pending_mask <= '0;
    end else begin
      for (int i = 0; i < PIPE_DEPTH; i++) r_slot[i] <= w_next[i];
      o_pending_mask <= w_mask;
    end
  end
endmodule

// File: rtl/reg_scoreboard_ctrl.sv
// reg_scoreboard_ctrl: RAW stall, flush hold sequencing and retire cross-check beside decode
module reg_scoreboard_ctrl import reg_scoreboard_ctrl_pkg::*; #(
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
  parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
  parameter int FLUSH_HOLD = DEF_FLUSH_HOLD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issueValid,
  input  logic                    issueWrReg,
  input  logic [REG_NO_WIDTH-1:0] issueDstNo,
  input  logic                    issueSrc1Use,
  input  logic [REG_NO_WIDTH-1:0] issueSrc1No,
  input  logic                    issueSrc2Use,
  input  logic [REG_NO_WIDTH-1:0] issueSrc2No,
  input  logic                    flush,
  input  logic                    retireWrReg,
  input  logic [REG_NO_WIDTH-1:0] retireNo,
  output logic                    issueAccept,
  output logic                    stall,
  output logic                    flushLatches,
  output logic [NUM_REGS-1:0]     pendingMask,
  output logic                    errMismatch
);
  localparam int CW = $clog2(FLUSH_HOLD + 1);
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic r_flush_latches, r_err;
  logic w_hazard, w_mis;
  slot_t w_tail;
  sb_slot_pipe #(.PIPE_DEPTH(PIPE_DEPTH), .FLUSH_DEPTH(FLUSH_DEPTH)) u_pipe (
    .clk           (clk),
    .reset         (reset),
    .i_push        (issueAccept && issueWrReg),
    .i_push_no     (issueDstNo),
    .i_flush       (flush),
    .i_src1_use    (issueSrc1Use),
    .i_src1_no     (issueSrc1No),
    .i_src2_use    (issueSrc2Use),
    .i_src2_no     (issueSrc2No),
    .o_tail        (w_tail),
    .o_hazard      (w_hazard),
    .o_pending_mask(pendingMask)
  );
  always_comb begin
    stall = (r_state == HOLD) ? 1'b1 : issueValid && w_hazard;
    issueAccept = issueValid && !stall && !flush && r_state == RUN;
    w_state_nxt = flush ? HOLD : (r_state == HOLD && r_cnt == CW'(1)) ? RUN : r_state;
    w_cnt_nxt = flush ? CW'(FLUSH_HOLD) : (r_state == HOLD) ? r_cnt - 1'b1 : r_cnt;
    // the oldest slot is what the MEM latch must be presenting this cycle
    w_mis = (retireWrReg != w_tail.valid) ||
            (retireWrReg && w_tail.valid && retireNo != w_tail.regNo);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt <= '0;
      r_flush_latches <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_flush_latches <= flush;
      r_err <= r_err | w_mis;
    end
  end
  assign flushLatches = r_flush_latches;
  assign errMismatch = r_err;
endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// tb_reg_scoreboard_ctrl: scenario tasks with a queue of expected stall/accept per driven cycle
module tb_reg_scoreboard_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic issueValid, issueWrReg, issueSrc1Use, issueSrc2Use, flush, retireWrReg;
  logic [3:0] issueDstNo, issueSrc1No, issueSrc2No, retireNo;
  logic issueAccept, stall, flushLatches, errMismatch;
  logic [15:0] pendingMask;
  int n_vec = 0, n_miss = 0;
  typedef struct packed {
    logic v, wr; logic [3:0] dst; logic u1; logic [3:0] s1; logic u2; logic [3:0] s2;
    logic fl, rw; logic [3:0] rn; logic est, eac;
  } vec_t;
  logic [1:0] exp_q [$];
  logic [1:0] e;

  always #5 clk = ~clk;

  reg_scoreboard_ctrl dut (
    .clk(clk), .reset(reset), .issueValid(issueValid), .issueWrReg(issueWrReg),
    .issueDstNo(issueDstNo), .issueSrc1Use(issueSrc1Use), .issueSrc1No(issueSrc1No),
    .issueSrc2Use(issueSrc2Use), .issueSrc2No(issueSrc2No), .flush(flush),
    .retireWrReg(retireWrReg), .retireNo(retireNo), .issueAccept(issueAccept),
    .stall(stall), .flushLatches(flushLatches), .pendingMask(pendingMask),
    .errMismatch(errMismatch)
  );

  function automatic vec_t V(input logic v, wr, input logic [3:0] dst, input logic u1,
                             input logic [3:0] s1, input logic u2, input logic [3:0] s2,
                             input logic fl, rw, input logic [3:0] rn, input logic est, eac);
    return '{v:v, wr:wr, dst:dst, u1:u1, s1:s1, u2:u2, s2:s2, fl:fl, rw:rw, rn:rn, est:est, eac:eac};
  endfunction

  task automatic apply(input vec_t x);
    @(negedge clk);
    issueValid = x.v; issueWrReg = x.wr; issueDstNo = x.dst;
    issueSrc1Use = x.u1; issueSrc1No = x.s1; issueSrc2Use = x.u2; issueSrc2No = x.s2;
    flush = x.fl; retireWrReg = x.rw; retireNo = x.rn;
    exp_q.push_back({x.est, x.eac});
    #2;
  endtask

  task automatic test_reset;
    apply(V(0,0,0,0,0,0,0,0,0,0,0,0));
    e = exp_q.pop_front(); n_vec++;
    if ({stall, issueAccept} !== e) begin n_miss++; $display("FAIL reset stall/accept got %b want %b", {stall, issueAccept}, e); end
    n_vec++;
    if ({pendingMask, flushLatches, errMismatch} !== 18'h0) begin
      n_miss++; $display("FAIL reset outputs got pm=%h fl=%b err=%b want 0", pendingMask, flushLatches, errMismatch);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_raw_stall;
    vec_t seq [6] = '{V(1,1,5,0,0,0,0,0,0,0,0,1), V(1,0,0,1,5,0,0,0,0,0,1,0),
                      V(1,0,0,1,5,0,0,0,0,0,1,0), V(1,0,0,1,5,0,0,0,1,5,1,0),
                      V(1,0,0,1,5,0,0,0,0,0,0,1), V(0,0,0,0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      apply(seq[i]);
      e = exp_q.pop_front(); n_vec++;
      if ({stall, issueAccept} !== e) begin n_miss++; $display("FAIL raw[%0d] stall/accept got %b want %b", i, {stall, issueAccept}, e); end
      if (i == 1) begin
        n_vec++;
        if (pendingMask !== 16'h0020) begin n_miss++; $display("FAIL raw pendingMask got %h want 0020", pendingMask); end
      end
    end
    n_vec++;
    if (errMismatch !== 1'b0) begin n_miss++; $display("FAIL raw errMismatch got %b want 0", errMismatch); end
  endtask

  task automatic test_independent;
    vec_t seq [6] = '{V(1,1,1,0,0,0,0,0,0,0,0,1), V(1,1,2,1,4,0,0,0,0,0,0,1),
                      V(1,1,3,0,0,1,5,0,0,0,0,1), V(0,0,0,0,0,0,0,0,1,1,0,0),
                      V(0,0,0,0,0,0,0,0,1,2,0,0), V(0,0,0,0,0,0,0,0,1,3,0,0)};
    for (int i = 0; i < 6; i++) begin
      apply(seq[i]);
      e = exp_q.pop_front(); n_vec++;
      if ({stall, issueAccept} !== e) begin n_miss++; $display("FAIL indep[%0d] stall/accept got %b want %b", i, {stall, issueAccept}, e); end
      if (i == 3) begin
        n_vec++;
        if (pendingMask !== 16'h000E) begin n_miss++; $display("FAIL indep pendingMask got %h want 000e", pendingMask); end
      end
    end
  endtask

  task automatic test_flush;
    vec_t seq [6] = '{V(1,1,7,0,0,0,0,0,0,0,0,1), V(1,1,8,0,0,0,0,0,0,0,0,1),
                      V(1,1,9,0,0,0,0,1,0,0,0,0), V(1,1,10,0,0,0,0,0,1,7,1,0),
                      V(1,1,10,0,0,0,0,0,0,0,1,0), V(1,0,0,0,0,0,0,0,0,0,0,1)};
    for (int i = 0; i < 6; i++) begin
      apply(seq[i]);
      e = exp_q.pop_front(); n_vec++;
      if ({stall, issueAccept} !== e) begin n_miss++; $display("FAIL flush[%0d] stall/accept got %b want %b", i, {stall, issueAccept}, e); end
      if (i == 3) begin
        n_vec++;
        if ({flushLatches, pendingMask} !== {1'b1, 16'h0080}) begin
          n_miss++; $display("FAIL flush t3 got fl=%b pm=%h want fl=1 pm=0080", flushLatches, pendingMask);
        end
      end
      if (i == 4) begin
        n_vec++;
        if (flushLatches !== 1'b0) begin n_miss++; $display("FAIL flush t4 flushLatches got %b want 0", flushLatches); end
      end
    end
    n_vec++;
    if (errMismatch !== 1'b0) begin n_miss++; $display("FAIL flush errMismatch got %b want 0", errMismatch); end
  endtask

  task automatic test_same_cycle;
    vec_t seq [8] = '{V(1,1,9,0,0,0,0,0,0,0,0,1), V(0,0,0,0,0,0,0,0,0,0,0,0),
                      V(0,0,0,0,0,0,0,0,0,0,0,0), V(1,1,9,0,0,0,0,0,1,9,0,1),
                      V(1,0,0,0,0,1,9,0,0,0,1,0), V(1,0,0,0,0,1,9,0,0,0,1,0),
                      V(1,0,0,0,0,1,9,0,1,9,1,0), V(1,0,0,0,0,1,9,0,0,0,0,1)};
    for (int i = 0; i < 8; i++) begin
      apply(seq[i]);
      e = exp_q.pop_front(); n_vec++;
      if ({stall, issueAccept} !== e) begin n_miss++; $display("FAIL same[%0d] stall/accept got %b want %b", i, {stall, issueAccept}, e); end
      if (i == 4) begin
        n_vec++;
        if (pendingMask !== 16'h0200) begin n_miss++; $display("FAIL same pendingMask got %h want 0200", pendingMask); end
      end
    end
    n_vec++;
    if (errMismatch !== 1'b0) begin n_miss++; $display("FAIL same errMismatch got %b want 0", errMismatch); end
  endtask

  task automatic test_mismatch;
    vec_t seq [7] = '{V(1,1,4,0,0,0,0,0,0,0,0,1), V(0,0,0,0,0,0,0,0,0,0,0,0),
                      V(0,0,0,0,0,0,0,0,0,0,0,0), V(0,0,0,0,0,0,0,0,1,6,0,0),
                      V(0,0,0,0,0,0,0,0,0,0,0,0), V(0,0,0,0,0,0,0,0,0,0,0,0),
                      V(0,0,0,0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < 7; i++) begin
      apply(seq[i]);
      e = exp_q.pop_front(); n_vec++;
      if ({stall, issueAccept} !== e) begin n_miss++; $display("FAIL mism[%0d] stall/accept got %b want %b", i, {stall, issueAccept}, e); end
      if (i == 3 || i == 6) begin
        n_vec++;
        if (errMismatch !== (i == 6)) begin n_miss++; $display("FAIL mism[%0d] errMismatch got %b want %b", i, errMismatch, i == 6); end
      end
    end
  endtask

  task automatic test_reset_mid_run;
    vec_t seq [4] = '{V(1,1,11,0,0,0,0,0,0,0,0,1), V(1,1,12,0,0,0,0,0,0,0,0,1),
                      V(0,0,0,0,0,0,0,1,0,0,0,0), V(0,0,0,0,0,0,0,0,1,11,1,0)};
    for (int i = 0; i < 4; i++) begin
      apply(seq[i]);
      e = exp_q.pop_front(); n_vec++;
      if ({stall, issueAccept} !== e) begin n_miss++; $display("FAIL rmid[%0d] stall/accept got %b want %b", i, {stall, issueAccept}, e); end
    end
    n_vec++;
    if ({pendingMask, flushLatches, errMismatch} !== {16'h0800, 1'b1, 1'b1}) begin
      n_miss++; $display("FAIL rmid pre-reset got pm=%h fl=%b err=%b want 0800 1 1", pendingMask, flushLatches, errMismatch);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({pendingMask, flushLatches, errMismatch} !== 18'h0) begin
      n_miss++; $display("FAIL rmid async reset got pm=%h fl=%b err=%b want 0", pendingMask, flushLatches, errMismatch);
    end
    @(negedge clk); reset = 1'b1;
    apply(V(1,0,0,1,11,0,0,0,0,0,0,1));
    e = exp_q.pop_front(); n_vec++;
    if ({stall, issueAccept} !== e) begin n_miss++; $display("FAIL rmid post stall/accept got %b want %b", {stall, issueAccept}, e); end
  endtask

  initial begin
    test_reset;
    test_raw_stall;
    test_independent;
    test_flush;
    test_same_cycle;
    test_mismatch;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
